// File: rtl/key_event_device_pkg.sv
// Shared register map and bit positions for the pushbutton device.
package key_event_device_pkg;

    localparam int unsigned KDATA_OFF   = 0;
    localparam int unsigned KCTRL_OFF   = 4;
    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 2;
    localparam int unsigned IE_BIT      = 8;
    localparam int unsigned CTRL_W      = 32;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hF000_0010;

    // Assemble the KCTRL read word; unlisted bits read as zero.
    function automatic logic [CTRL_W-1:0] kctrl_word(input logic ready,
                                                     input logic overrun,
                                                     input logic ie);
        logic [CTRL_W-1:0] w;
        w              = '0;
        w[READY_BIT]   = ready;
        w[OVERRUN_BIT] = overrun;
        w[IE_BIT]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/key_change_detect.sv
// Normalises key polarity and flags any level change after the first
// post-reset edge, so keys held through reset are never reported.
module key_change_detect #(
    parameter int unsigned NKEYS      = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys_db,
    output logic [NKEYS-1:0] pressed,
    output logic             change
);

    logic [NKEYS-1:0] key_prev_q;
    logic             primed_q;

    assign pressed = ACTIVE_LOW ? ~keys_db : keys_db;
    assign change  = primed_q && (pressed != key_prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            key_prev_q <= pressed;
            primed_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/key_event_device.sv
// Memory-mapped pushbutton device: KDATA/KCTRL registers, Ready/Overrun
// event tracking and a level interrupt request.
module key_event_device
    import key_event_device_pkg::*;
#(
    parameter int unsigned          NKEYS      = 4,
    parameter int unsigned          DBITS      = 32,
    parameter bit                   ACTIVE_LOW = 1'b1,
    parameter logic [DBITS-1:0]     BASE_ADDR  = DBITS'(DEFAULT_BASE_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys_db,
    input  logic [DBITS-1:0] abus,
    input  logic             we,
    input  logic             re,
    input  logic [DBITS-1:0] dbus_in,
    output logic [DBITS-1:0] dbus_out,
    output logic             drive,
    output logic             intr
);

    localparam logic [DBITS-1:0] KDATA_ADDR = BASE_ADDR + DBITS'(KDATA_OFF);
    localparam logic [DBITS-1:0] KCTRL_ADDR = BASE_ADDR + DBITS'(KCTRL_OFF);

    logic [NKEYS-1:0] pressed;
    logic             change;

    logic [NKEYS-1:0] kdata_q, kdata_d;
    logic             ready_q, ready_d;
    logic             overrun_q, overrun_d;
    logic             ie_q, ie_d;

    logic             sel_kdata, sel_kctrl;
    logic             kdata_rd, kctrl_wr;
    logic             unused_dbus_in;

    key_change_detect #(
        .NKEYS      (NKEYS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_detect (
        .clk     (clk),
        .reset   (reset),
        .keys_db (keys_db),
        .pressed (pressed),
        .change  (change)
    );

    assign sel_kdata = (abus == KDATA_ADDR);
    assign sel_kctrl = (abus == KCTRL_ADDR);
    assign kdata_rd  = re && sel_kdata;
    assign kctrl_wr  = we && sel_kctrl;

    assign unused_dbus_in = ^dbus_in;

    // A new change always wins over any clear in the same cycle.
    always_comb begin
        kdata_d   = pressed;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        ie_d      = ie_q;

        if (change) begin
            ready_d = 1'b1;
        end else if (kdata_rd) begin
            ready_d = 1'b0;
        end else if (kctrl_wr && !dbus_in[READY_BIT]) begin
            ready_d = 1'b0;
        end

        if (change && ready_q && !kdata_rd) begin
            overrun_d = 1'b1;
        end else if (kctrl_wr && !dbus_in[OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end

        if (kctrl_wr) begin
            ie_d = dbus_in[IE_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kdata_q   <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            kdata_q   <= kdata_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            ie_q      <= ie_d;
        end
    end

    // Zero-latency load path straight from the registers.
    always_comb begin
        dbus_out = '0;
        if (re && sel_kdata) begin
            dbus_out = DBITS'(kdata_q);
        end else if (re && sel_kctrl) begin
            dbus_out = DBITS'(kctrl_word(ready_q, overrun_q, ie_q));
        end
    end

    assign drive = re && (sel_kdata || sel_kctrl);
    assign intr  = ready_q && ie_q;

endmodule
